// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects/strobes.
// Latency: 2 (j/jal/jr), 3 (beq), 4 (sw, R-type/ori/lui), 5 (lw) cycles, plus one per memory wait cycle.
// Backpressure: mem_ready low stalls FETCH/MEM; MEM_TIMEOUT consecutive low cycles in one access enter ERR.
//
// Ports:
//   clk, reset (async, active-low)       clock and reset
//   opcode, funct, zero                  instruction fields and ALU equality flag
//   mem_ready                            memory completes the current access this cycle
//   pc_write, ir_write, reg_write,       datapath strobes
//   mem_read, mem_write
//   npc_op, a3op, regop, alu_bop,        datapath mux selects / ALU control
//   alu_op, zero_ext
//   state, instr_done, err               debug state, retire pulse, sticky error
// Optional feature: define MC_PERF_CNT_EN to add 32-bit cyc_cnt / ins_cnt outputs.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  npc_op,
    output logic [1:0]  a3op,
    output logic [1:0]  regop,
    output logic [1:0]  alu_bop,
    output logic [3:0]  alu_op,
    output logic        zero_ext,
    output logic [2:0]  state,
    output logic        instr_done,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] ins_cnt,
`endif
    output logic        err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t         cur_st;
    state_t         nxt_st;
    logic [CW-1:0]  wait_cnt;
    logic [CW-1:0]  wait_nxt;
    logic           timeout_hit;

    // instruction decode
    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_j, is_jal, is_beq, is_ori, is_lui, is_lw, is_sw, is_legal;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_legal = is_addu | is_subu | is_jr | is_j | is_jal | is_beq |
                      is_ori | is_lui | is_lw | is_sw;

    // The current low-ready cycle is the MEM_TIMEOUT-th in a row: give up at
    // the coming edge. A ready in this same cycle completes the access instead.
    assign timeout_hit = !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    // ungated control decode
    logic       pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;
    logic [2:0] npc_op_c;
    logic [1:0] a3op_c, regop_c, alu_bop_c;
    logic [3:0] alu_op_c;
    logic       zero_ext_c, instr_done_c;

    always_comb begin
        nxt_st       = cur_st;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        npc_op_c     = 3'd0;
        a3op_c       = 2'd0;
        regop_c      = 2'd0;
        alu_bop_c    = 2'd0;
        alu_op_c     = 4'd0;
        zero_ext_c   = 1'b0;
        instr_done_c = 1'b0;

        case (cur_st)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt_st     = S_DECODE;
                end else if (timeout_hit) begin
                    nxt_st = S_ERR;
                end
            end

            S_DECODE: begin
                if (!is_legal) begin
                    nxt_st = S_ERR;
                end else if (is_j || is_jal) begin
                    pc_write_c   = 1'b1;
                    npc_op_c     = 3'd2;
                    instr_done_c = 1'b1;
                    nxt_st       = S_FETCH;
                    if (is_jal) begin
                        // link register gets PC+4, already in the PC
                        reg_write_c = 1'b1;
                        a3op_c      = 2'd2;
                        regop_c     = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_write_c   = 1'b1;
                    npc_op_c     = 3'd3;
                    instr_done_c = 1'b1;
                    nxt_st       = S_FETCH;
                end else begin
                    nxt_st = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_op_c   = (is_subu || is_beq) ? 4'd1 : (is_ori ? 4'd2 : 4'd0);
                alu_bop_c  = (is_ori || is_lw || is_sw) ? 2'd1 : (is_lui ? 2'd2 : 2'd0);
                zero_ext_c = is_ori;
                if (is_beq) begin
                    pc_write_c   = zero;
                    npc_op_c     = 3'd1;
                    instr_done_c = 1'b1;
                    nxt_st       = S_FETCH;
                end else if (is_lw || is_sw) begin
                    nxt_st = S_MEM;
                end else begin
                    nxt_st = S_WB;
                end
            end

            S_MEM: begin
                if (is_lw) begin
                    mem_read_c = 1'b1;
                    if (mem_ready)        nxt_st = S_WB;
                    else if (timeout_hit) nxt_st = S_ERR;
                end else if (is_sw) begin
                    mem_write_c = 1'b1;
                    if (mem_ready) begin
                        instr_done_c = 1'b1;
                        nxt_st       = S_FETCH;
                    end else if (timeout_hit) begin
                        nxt_st = S_ERR;
                    end
                end else begin
                    // IR cannot legally change mid-instruction; treat as corruption
                    nxt_st = S_ERR;
                end
            end

            S_WB: begin
                reg_write_c  = 1'b1;
                a3op_c       = is_rtype ? 2'd1 : 2'd0;
                regop_c      = is_lw ? 2'd1 : 2'd0;
                instr_done_c = 1'b1;
                nxt_st       = S_FETCH;
            end

            S_ERR: begin
                nxt_st = S_ERR;
            end

            default: begin
                nxt_st = S_FETCH;
            end
        endcase
    end

    // Wait counter runs only while a memory access is stalled in place.
    always_comb begin
        wait_nxt = '0;
        if ((cur_st == S_FETCH || cur_st == S_MEM) && !mem_ready && (nxt_st == cur_st))
            wait_nxt = wait_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st   <= S_FETCH;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            cur_st   <= nxt_st;
            wait_cnt <= wait_nxt;
            if (nxt_st == S_ERR)
                err <= 1'b1;
        end
    end

    // Everything is held at 0 while reset is low so a half-done instruction
    // cannot strobe the datapath during reset.
    always_comb begin
        pc_write   = reset & pc_write_c;
        ir_write   = reset & ir_write_c;
        reg_write  = reset & reg_write_c;
        mem_read   = reset & mem_read_c;
        mem_write  = reset & mem_write_c;
        instr_done = reset & instr_done_c;
        npc_op     = reset ? npc_op_c   : 3'd0;
        a3op       = reset ? a3op_c     : 2'd0;
        regop      = reset ? regop_c    : 2'd0;
        alu_bop    = reset ? alu_bop_c  : 2'd0;
        alu_op     = reset ? alu_op_c   : 4'd0;
        zero_ext   = reset & zero_ext_c;
    end

    assign state = cur_st;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= 32'd0;
            ins_cnt <= 32'd0;
        end else begin
            if (cur_st != S_ERR)
                cyc_cnt <= cyc_cnt + 32'd1;
            if (instr_done)
                ins_cnt <= ins_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction sequences with per-cycle expected outputs
// and per-instruction retire latencies pushed to queues, checked by a negedge monitor.
// Runs with MEM_TIMEOUT = 4 so the timeout boundary is short.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    logic [2:0]  npc_op;
    logic [1:0]  a3op, regop, alu_bop;
    logic [3:0]  alu_op;
    logic        zero_ext;
    logic [2:0]  state;
    logic        instr_done, err;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .npc_op     (npc_op),
        .a3op       (a3op),
        .regop      (regop),
        .alu_bop    (alu_bop),
        .alu_op     (alu_op),
        .zero_ext   (zero_ext),
        .state      (state),
        .instr_done (instr_done),
`ifdef MC_PERF_CNT_EN
        .cyc_cnt    (cyc_cnt),
        .ins_cnt    (ins_cnt),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    // strb = {pc_write, ir_write, reg_write, mem_read, mem_write}
    typedef struct packed {
        logic [2:0] st;
        logic [4:0] strb;
        logic [2:0] npc;
        logic [1:0] a3;
        logic [1:0] rg;
        logic [1:0] bop;
        logic [3:0] aop;
        logic       ze;
        logic       dn;
        logic       er;
    } exp_t;

    exp_t  exq[$];
    string nmq[$];
    int    latq[$];
    int    tests = 0;
    int    fails = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic [4:0] strb,
                                input logic [2:0] npc, input logic [1:0] a3,
                                input logic [1:0] rg, input logic [1:0] bop,
                                input logic [3:0] aop, input logic ze,
                                input logic dn, input logic er);
        exp_t r;
        r.st = st; r.strb = strb; r.npc = npc; r.a3 = a3; r.rg = rg;
        r.bop = bop; r.aop = aop; r.ze = ze; r.dn = dn; r.er = er;
        return r;
    endfunction

    // ---------------- monitor ----------------
    exp_t  act_r, exp_r;
    string nm_r;
    int    lat = 0;
    int    lat_exp;

    always @(negedge clk) begin
        act_r.st   = state;
        act_r.strb = {pc_write, ir_write, reg_write, mem_read, mem_write};
        act_r.npc  = npc_op;
        act_r.a3   = a3op;
        act_r.rg   = regop;
        act_r.bop  = alu_bop;
        act_r.aop  = alu_op;
        act_r.ze   = zero_ext;
        act_r.dn   = instr_done;
        act_r.er   = err;
        if (exq.size() > 0) begin
            exp_r = exq.pop_front();
            nm_r  = nmq.pop_front();
            tests++;
            if (act_r !== exp_r) begin
                fails++;
                $display("FAIL %s: got st=%0d strb=%b npc=%0d a3=%0d rg=%0d bop=%0d aop=%0d ze=%b dn=%b err=%b, expected st=%0d strb=%b npc=%0d a3=%0d rg=%0d bop=%0d aop=%0d ze=%b dn=%b err=%b",
                         nm_r, act_r.st, act_r.strb, act_r.npc, act_r.a3, act_r.rg, act_r.bop,
                         act_r.aop, act_r.ze, act_r.dn, act_r.er,
                         exp_r.st, exp_r.strb, exp_r.npc, exp_r.a3, exp_r.rg, exp_r.bop,
                         exp_r.aop, exp_r.ze, exp_r.dn, exp_r.er);
            end
        end
        if (!reset) begin
            lat = 0;
        end else begin
            lat++;
            if (instr_done) begin
                tests++;
                if (latq.size() == 0) begin
                    fails++;
                    $display("FAIL retire_latency: unexpected retirement after %0d cycles", lat);
                end else begin
                    lat_exp = latq.pop_front();
                    if (lat != lat_exp) begin
                        fails++;
                        $display("FAIL retire_latency: got %0d cycles, expected %0d", lat, lat_exp);
                    end
                end
                lat = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input exp_t e, input string nm);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        exq.push_back(e);
        nmq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic fetch_ok(input logic [5:0] op, input logic [5:0] fn);
        cyc(op, fn, 1'b0, 1'b1, mk(0, 5'b11010, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
    endtask

    task automatic fetch_wait(input logic [5:0] op, input logic [5:0] fn);
        cyc(op, fn, 1'b0, 1'b0, mk(0, 5'b00010, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
    endtask

    task automatic decode_plain(input logic [5:0] op, input logic [5:0] fn, input string nm);
        cyc(op, fn, 1'b0, 1'b1, mk(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0), nm);
    endtask

    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input string nm,
                           input logic [3:0] aop, input logic [1:0] bop,
                           input logic ze, input logic [1:0] a3);
        latq.push_back(4);
        fetch_ok(op, fn);
        decode_plain(op, fn, {nm, "_decode"});
        cyc(op, fn, 1'b0, 1'b1, mk(2, 5'b00000, 0, 0, 0, bop, aop, ze, 0, 0), {nm, "_exec"});
        cyc(op, fn, 1'b0, 1'b1, mk(4, 5'b00100, 0, a3, 0, 0, 0, 0, 1, 0), {nm, "_wb"});
    endtask

    task automatic run_beq(input logic z);
        latq.push_back(3);
        fetch_ok(6'h04, 6'h00);
        decode_plain(6'h04, 6'h00, "beq_decode");
        cyc(6'h04, 6'h00, z, 1'b1, mk(2, {z, 4'b0000}, 1, 0, 0, 0, 1, 0, 1, 0), "beq_exec");
    endtask

    task automatic run_jump(input logic [5:0] op, input logic [5:0] fn, input exp_t d, input string nm);
        latq.push_back(2);
        fetch_ok(op, fn);
        cyc(op, fn, 1'b0, 1'b1, d, nm);
    endtask

    task automatic reset_cycle(input string nm);
        reset = 1'b0;
        cyc(opcode, funct, 1'b0, 1'b1, mk(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0), nm);
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_cycle("reset_hold");
        reset_cycle("reset_hold");
`ifdef MC_PERF_CNT_EN
        chk32("cyc_cnt_reset", cyc_cnt, 32'd0);
        chk32("ins_cnt_reset", ins_cnt, 32'd0);
`endif
        reset = 1'b1;

        run_alu(6'h00, 6'h21, "addu", 4'd0, 2'd0, 1'b0, 2'd1);
        run_alu(6'h00, 6'h23, "subu", 4'd1, 2'd0, 1'b0, 2'd1);
        run_alu(6'h0D, 6'h00, "ori",  4'd2, 2'd1, 1'b1, 2'd0);
        run_alu(6'h0F, 6'h00, "lui",  4'd0, 2'd2, 1'b0, 2'd0);

        // lw with three MEM wait cycles
        latq.push_back(8);
        fetch_ok(6'h23, 6'h00);
        decode_plain(6'h23, 6'h00, "lw_decode");
        cyc(6'h23, 6'h00, 1'b0, 1'b1, mk(2, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0), "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(6'h23, 6'h00, 1'b0, 1'b0, mk(3, 5'b00010, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_wait");
        cyc(6'h23, 6'h00, 1'b0, 1'b1, mk(3, 5'b00010, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_rdy");
        cyc(6'h23, 6'h00, 1'b0, 1'b1, mk(4, 5'b00100, 0, 0, 1, 0, 0, 0, 1, 0), "lw_wb");

        // sw with two MEM wait cycles, retires from MEM
        latq.push_back(6);
        fetch_ok(6'h2B, 6'h00);
        decode_plain(6'h2B, 6'h00, "sw_decode");
        cyc(6'h2B, 6'h00, 1'b0, 1'b1, mk(2, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0), "sw_exec");
        for (int i = 0; i < 2; i++)
            cyc(6'h2B, 6'h00, 1'b0, 1'b0, mk(3, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0), "sw_mem_wait");
        cyc(6'h2B, 6'h00, 1'b0, 1'b1, mk(3, 5'b00001, 0, 0, 0, 0, 0, 0, 1, 0), "sw_mem_rdy");

        run_beq(1'b1);
        run_beq(1'b0);
        run_jump(6'h03, 6'h00, mk(1, 5'b10100, 2, 2, 2, 0, 0, 0, 1, 0), "jal_decode");
        run_jump(6'h02, 6'h00, mk(1, 5'b10000, 2, 0, 0, 0, 0, 0, 1, 0), "j_decode");
        run_jump(6'h00, 6'h08, mk(1, 5'b10000, 3, 0, 0, 0, 0, 0, 1, 0), "jr_decode");

        // three fetch waits, ready arrives on the 4th fetch cycle: no error
        latq.push_back(5);
        for (int i = 0; i < 3; i++) fetch_wait(6'h02, 6'h00);
        fetch_ok(6'h02, 6'h00);
        cyc(6'h02, 6'h00, 1'b0, 1'b1, mk(1, 5'b10000, 2, 0, 0, 0, 0, 0, 1, 0), "j_after_wait");

`ifdef MC_PERF_CNT_EN
        chk32("ins_cnt_run", ins_cnt, 32'd12);
        chk32("cyc_cnt_run", cyc_cnt, 32'd47);
`endif

        // reset during MEM of lw
        fetch_ok(6'h23, 6'h00);
        decode_plain(6'h23, 6'h00, "lw2_decode");
        cyc(6'h23, 6'h00, 1'b0, 1'b1, mk(2, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0), "lw2_exec");
        cyc(6'h23, 6'h00, 1'b0, 1'b0, mk(3, 5'b00010, 0, 0, 0, 0, 0, 0, 0, 0), "lw2_mem_wait");
        reset_cycle("rst_mid_mem");
`ifdef MC_PERF_CNT_EN
        chk32("cyc_cnt_midrst", cyc_cnt, 32'd0);
        chk32("ins_cnt_midrst", ins_cnt, 32'd0);
`endif
        reset_cycle("rst_mid_mem_hold");
        reset = 1'b1;
        run_alu(6'h00, 6'h21, "addu2", 4'd0, 2'd0, 1'b0, 2'd1);

        // fetch timeout: four low-ready cycles -> ERR, sticky
        for (int i = 0; i < 4; i++) fetch_wait(6'h02, 6'h00);
        for (int i = 0; i < 3; i++)
            cyc(6'h02, 6'h00, 1'b0, 1'b1, mk(5, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1), "timeout_err_sticky");
        reset_cycle("rst_clear_err");
        reset = 1'b1;

        // illegal opcode
        fetch_ok(6'h3F, 6'h00);
        decode_plain(6'h3F, 6'h00, "illegal_op_decode");
        for (int i = 0; i < 2; i++)
            cyc(6'h3F, 6'h00, 1'b0, 1'b1, mk(5, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1), "illegal_op_err");
        reset_cycle("rst_after_illegal_op");
        reset = 1'b1;

        // illegal R-type funct
        fetch_ok(6'h00, 6'h20);
        decode_plain(6'h00, 6'h20, "illegal_fn_decode");
        cyc(6'h00, 6'h20, 1'b0, 1'b1, mk(5, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1), "illegal_fn_err");
        reset_cycle("rst_after_illegal_fn");
        reset = 1'b1;

        run_jump(6'h02, 6'h00, mk(1, 5'b10000, 2, 0, 0, 0, 0, 0, 1, 0), "j_recover");

        for (int i = 0; i < 20 && exq.size() > 0; i++) @(negedge clk);
        tests++;
        if (exq.size() != 0 || latq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d cycle checks and %0d retirements outstanding, expected 0 and 0",
                     exq.size(), latq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the next-generation MIPS core. It replaces the purely combinational per-instruction decoder with a state machine that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the existing datapath's mux selects and write enables. Memory accesses use a ready handshake with a bounded wait, so the core tolerates multi-cycle instruction and data memories. It sits between the `mips` top level and the datapath, in place of the single-cycle controller.

## Interface
- `MEM_TIMEOUT`, 15: maximum consecutive cycles with `mem_ready` low in one memory access before entering ERR; legal range 1..255.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality result, sampled in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write` out 1: datapath strobes.
- `npc_op` out 3: 0 = PC+4, 1 = branch, 2 = j/jal target, 3 = jr (rs).
- `a3op` out 2: 0 = rt, 1 = rd, 2 = $31.
- `regop` out 2: 0 = ALU, 1 = MEM, 2 = PC (already PC+4).
- `alu_bop` out 2: 0 = rt, 1 = ext imm, 2 = imm<<16.
- `alu_op` out 4: 0 = add, 1 = sub, 2 = or.
- `zero_ext` out 1: 1 selects zero extension (ori), else sign extension.
- `state` out 3: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final cycle of every retired instruction.
- `err` out 1: sticky error, set on entry to ERR.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. Encodings 6 and 7 go to FETCH.
- Supported instructions:
  - R-type (`opcode` 0): addu (`funct` 0x21), subu (0x23), jr (0x08).
  - I/J-type opcodes: ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
  - Any other opcode/funct is illegal and goes to ERR at DECODE.
- FETCH:
  - Assert `mem_read`.
  - On `mem_ready`: assert `ir_write` and `pc_write` (`npc_op`=0), go to DECODE.
- DECODE:
  - j: `pc_write`, `npc_op`=2, `instr_done`; go to FETCH.
  - jal: as j, plus `reg_write`, `a3op`=2, `regop`=2.
  - jr: `pc_write`, `npc_op`=3, `instr_done`; go to FETCH.
  - All other legal instructions: go to EXEC.
- EXEC:
  - `alu_op`/`alu_bop`/`zero_ext` are decoded.
  - beq: `alu_op`=sub; `pc_write`=`zero`, `npc_op`=1; `instr_done`; go to FETCH.
  - lw/sw: go to MEM, with `alu_bop`=1 and sign extension.
  - R-type, ori, lui: go to WB.
- MEM:
  - lw: assert `mem_read`; on `mem_ready` go to WB.
  - sw: assert `mem_write`; on `mem_ready` pulse `instr_done` and go to FETCH.
- WB:
  - `reg_write`; `a3op`=1 for R-type, else 0; `regop`=1 for lw, else 0.
  - `instr_done`; go to FETCH.
- ERR: all strobes 0, `err`=1. Only reset leaves ERR.
- Outputs are combinational from `state`, `opcode`, `funct` and `zero`. All strobes default to 0.

## Timing
- Reset values:
  - `state`=FETCH, wait counter=0, `err`=0.
  - While `reset` is low, every strobe and `instr_done` is forced to 0.
- Cycle counts with zero memory wait:
  - j/jal/jr: 2 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - R-type/ori/lui: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `mem_ready` low in FETCH/MEM adds one cycle.
- Wait counter:
  - Width `$clog2(MEM_TIMEOUT+1)`.
  - Increments per FETCH/MEM cycle with `mem_ready` low.
  - Clears on `mem_ready` and on every state change.
  - Reaching `MEM_TIMEOUT` moves to ERR on the next edge.
  - If `mem_ready` is high in the same cycle the count reaches `MEM_TIMEOUT`, ready wins and the access completes.
- Reset asserted mid-instruction: immediate return to FETCH. The partial instruction has no effect after reset.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - Adds 32-bit outputs `cyc_cnt` and `ins_cnt`, both reset to 0.
  - `cyc_cnt` increments every cycle outside ERR.
  - `ins_cnt` increments on `instr_done`.
  - Both wrap at 2^32.
- `MC_PERF_CNT_EN` undefined: these ports and counters are absent. Other behaviour is identical.

## Test plan
- Release reset with `mem_ready`=1 and addu (0x00, 0x21) → states 0,1,2,4. In WB: `reg_write`=1, `a3op`=1, `regop`=0. `instr_done` in cycle 4.
- lw (0x23) with `mem_ready` low for 3 MEM cycles → 8 cycles total; `regop`=1 in WB. sw (0x2B) → `mem_write` is held during the wait and the instruction retires from MEM.
- beq with `zero`=1 → `pc_write`=1, `npc_op`=1 in EXEC. Same with `zero`=0 → `pc_write`=0. Both take 3 cycles.
- jal → in DECODE: `pc_write`=1, `npc_op`=2, `reg_write`=1, `a3op`=2, `regop`=2. Total 2 cycles.
- `mem_ready` held low in FETCH with `MEM_TIMEOUT`=4 → ERR after 4 wait cycles, `err`=1 and sticky. Ready arriving on the 4th wait cycle → no error. Opcode 0x3F → ERR from DECODE.
- Assert reset during MEM of lw → outputs 0 at once, `state`=0. With `MC_PERF_CNT_EN` defined, both counters read 0 after reset.
